// File: rtl/sram_controller.sv
// 32-bit CPU data port onto a 16-bit asynchronous SRAM.
// Each word access is split into a low and a high halfword phase.
module sram_controller #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_o,
   input  logic [15:0] sram_dq_i,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        op_wr, op_wr_nxt;
   logic [31:0] offset;
   logic [16:0] idx;
   logic        last;

   // Addresses below BASE_ADDR wrap silently into the top of the SRAM.
   assign offset = address - 32'(BASE_ADDR);
   assign idx    = offset[18:2];
   assign last   = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_wr     <= 1'b0;
         read_data <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         op_wr <= op_wr_nxt;
         if (state == LOW && !op_wr && last)
            read_data[15:0] <= sram_dq_i;
         if (state == HIGH && !op_wr && last)
            read_data[31:16] <= sram_dq_i;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      op_wr_nxt  = op_wr;
      ready      = 1'b0;
      sram_addr  = '0;
      sram_dq_o  = '0;
      sram_dq_oe = 1'b0;
      sram_we_n  = 1'b1;
      unique case (state)
         IDLE: begin
            ready = !(rd_en || wr_en);
            if (rd_en || wr_en) begin
               op_wr_nxt = wr_en;
               cnt_nxt   = '0;
               state_nxt = LOW;
            end
         end
         LOW: begin
            sram_addr = {idx, 1'b0};
            if (op_wr) begin
               sram_dq_o  = write_data[15:0];
               sram_dq_oe = 1'b1;
               sram_we_n  = 1'b0;
            end
            if (last) begin
               cnt_nxt   = '0;
               state_nxt = HIGH;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         HIGH: begin
            sram_addr = {idx, 1'b1};
            if (op_wr) begin
               sram_dq_o  = write_data[31:16];
               sram_dq_oe = 1'b1;
               sram_we_n  = 1'b0;
            end
            if (last) begin
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         DONE: begin
            ready     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL provide parameter BASE_ADDR, default 1024, the CPU byte address that maps to SRAM halfword 0.
REQ-002 The block SHALL provide parameter WAIT_CYCLES, default 2, range 1..15, the number of clk cycles each SRAM halfword access lasts.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port wr_en, input, 1, the write request from the MEM stage.
REQ-006 The block SHALL have port rd_en, input, 1, the read request from the MEM stage.
REQ-007 The block SHALL have port address, input, 32, the CPU byte address.
REQ-008 The block SHALL have port write_data, input, 32, the store data.
REQ-009 The block SHALL have port read_data, output, 32, the registered load data.
REQ-010 The block SHALL have port ready, output, 1; when it is low the CPU pipeline freezes.
REQ-011 The block SHALL have port sram_addr, output, 18, the SRAM halfword address.
REQ-012 The block SHALL have port sram_dq_o, output, 16, the SRAM write data.
REQ-013 The block SHALL have port sram_dq_i, input, 16, the SRAM read data.
REQ-014 The block SHALL have port sram_dq_oe, output, 1, the data bus drive enable.
REQ-015 The block SHALL have port sram_we_n, output, 1, the active-low SRAM write strobe.

Function
REQ-016 The block SHALL implement an FSM with the states IDLE, LOW, HIGH and DONE.
REQ-017 IDLE, rd_en=wr_en=0: ready SHALL be 1, sram_we_n SHALL be 1, sram_dq_oe SHALL be 0, and the FSM SHALL stay in IDLE.
REQ-018 IDLE, rd_en|wr_en=1: ready SHALL drop to 0 combinationally in the same cycle, the operation SHALL be latched (write when wr_en=1, else read), the phase counter SHALL clear, and the FSM SHALL go to LOW.
REQ-019 When wr_en and rd_en are both 1, the write SHALL take priority.
REQ-020 The word index SHALL be ((address - BASE_ADDR) >> 2) truncated to 17 bits; address values below BASE_ADDR wrap modulo 2^17 and are not flagged.
REQ-021 In LOW, sram_addr SHALL be {word index, 1'b0}; in HIGH, sram_addr SHALL be {word index, 1'b1}.
REQ-022 Writes: in LOW, sram_dq_o SHALL be write_data[15:0]; in HIGH, sram_dq_o SHALL be write_data[31:16]; in both, sram_dq_oe SHALL be 1 and sram_we_n SHALL be 0 for every cycle of the phase.
REQ-023 Reads: sram_dq_oe SHALL be 0 and sram_we_n SHALL be 1; sram_dq_i SHALL be captured on the last cycle of LOW into read_data[15:0] and on the last cycle of HIGH into read_data[31:16].
REQ-024 Each of LOW and HIGH SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter that clears on every phase change.
REQ-025 DONE SHALL last exactly one cycle with ready=1, sram_we_n=1 and sram_dq_oe=0, then go to IDLE unconditionally.
REQ-026 Latency: with the request seen in IDLE in cycle 0, ready SHALL be 1 in cycle 2*WAIT_CYCLES+1 (default: cycle 5).
REQ-027 The CPU holds address, write_data, rd_en and wr_en stable while ready=0; the block SHALL use the live inputs, not copies, for address and data.
REQ-028 A request still asserted in DONE SHALL NOT start a new access; the next access SHALL start only from IDLE.
REQ-029 read_data SHALL hold its value until the next read overwrites it, and writes SHALL NOT change it.
REQ-030 In IDLE, sram_addr SHALL be 0 and sram_dq_o SHALL be 0.

Reset
REQ-031 With rst=1 at a clock edge, the next state SHALL be IDLE, and the counter and latched operation SHALL be 0.
REQ-032 After reset, read_data SHALL be 0, sram_we_n SHALL be 1, sram_dq_oe SHALL be 0 and ready SHALL be 1, provided no request is asserted.
REQ-033 Reset during LOW, HIGH or DONE SHALL abort the access, with sram_we_n high from the next cycle; a partial write is permitted in the SRAM.

Verification
REQ-034 Write then read, default parameters: wr_en=1, address=1028, write_data=0xDEADBEEF -> sram_addr=2 with dq_o=0xBEEF for 2 cycles, then sram_addr=3 with dq_o=0xDEAD for 2 cycles, ready=1 in cycle 5. Then rd_en=1 at 1028 with the SRAM model returning the stored data -> read_data=0xDEADBEEF with ready=1 in cycle 5.
REQ-035 Simultaneous request: rd_en=wr_en=1, address=1024, write_data=0x12345678 -> write performed (sram_we_n=0, addresses 0 and 1), read_data unchanged.
REQ-036 Back-to-back requests: rd_en held high for 2 requests -> DONE→IDLE→LOW sequence, with exactly 2 accesses in 12 cycles and ready high for exactly 1 cycle between them.
REQ-037 Reset mid-write: rst=1 in the second LOW cycle -> next cycle IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0.
REQ-038 WAIT_CYCLES=1 and wrap: address=1020 -> word index 0x1FFFF, sram_addr 0x3FFFE then 0x3FFFF, ready=1 in cycle 3.
